// File: rtl/booth_seq_mul.sv
// ---------------------------------------------------------------------------
// booth_seq_mul
//
// Iterative radix-4 Booth multiplier. It retires one Booth digit per clock
// and returns the full 2*WIDTH-bit product. Operand and result transfers use
// valid/ready handshakes. This block is the multi-cycle MUL/MULH unit of the
// execute stage.
//
// Both operands are extended to WIDTH+2 bits before the digits are
// generated. The extension is a sign extension for signed operations and a
// zero extension for unsigned ones. This yields D = WIDTH/2+1 digits, so
// full-range unsigned operands produce an exact product.
//
// Parameters:
//   WIDTH  operand width in bits (even, >= 4)
//   CNT_W  width of the internal digit counter
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    operands and mode presented
//   in_ready    block can accept operands (IDLE)
//   a           multiplicand
//   b           multiplier
//   alu_signed  1 = signed operands, 0 = unsigned operands
//   out_valid   result valid (DONE)
//   out_ready   consumer accepts result
//   product     full 2*WIDTH-bit product
//   neg_flag    product is negative (signed mode only)
//   zero_flag   product is zero
//   busy        multiplier is iterating (CALC)
//
// Optional build macro:
//   BOOTH_EARLY_TERM_EN  leave CALC as soon as every remaining Booth digit
//                        is zero. The result is the same; only the latency
//                        becomes shorter.
// ---------------------------------------------------------------------------
module booth_seq_mul #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH/2+2)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               alu_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               neg_flag,
    output logic               zero_flag,
    output logic               busy
);

    localparam int PW = 2*WIDTH;
    localparam int MW = WIDTH+3;
    localparam int D  = WIDTH/2+1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(D-1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [PW-1:0]     mcand;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     addend;
    logic [PW-1:0]     acc_sum;
    logic [PW-1:0]     product_r;
    logic [MW-1:0]     mplier;
    logic [MW-1:0]     mplier_shifted;
    logic [CNT_W-1:0]  cnt;
    logic              sgn_r;
    logic              neg_r;
    logic              zero_r;
    logic              last_digit;
    logic              finish;
    logic              ext_a;
    logic              ext_b;

    // Extension bits for the two operands. Unsigned mode forces them to zero.
    assign ext_a = alu_signed & a[WIDTH-1];
    assign ext_b = alu_signed & b[WIDTH-1];

    // Radix-4 Booth recoding of the low three multiplier bits into a
    // multiple of the current (pre-shifted) multiplicand. All arithmetic
    // wraps modulo 2^(2*WIDTH). This wrap is what the product width needs.
    always_comb begin
        addend = '0;
        case (mplier[2:0])
            3'b001, 3'b010: addend = mcand;
            3'b011:         addend = {mcand[PW-2:0], 1'b0};
            3'b100:         addend = -{mcand[PW-2:0], 1'b0};
            3'b101, 3'b110: addend = -mcand;
            default:        addend = '0;
        endcase
    end

    assign acc_sum        = acc + addend;
    assign mplier_shifted = {{2{mplier[MW-1]}}, mplier[MW-1:2]};
    assign last_digit     = (cnt == LAST_CNT);

    // If the shifted multiplier holds only zeros or only ones, every digit
    // still to come decodes to zero. Stopping at that point leaves acc
    // unchanged.
`ifdef BOOTH_EARLY_TERM_EN
    assign finish = last_digit | (&mplier_shifted) | ~(|mplier_shifted);
`else
    assign finish = last_digit;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. The outputs depend only on the state.
    // As a result, in_valid is ignored while CALC or DONE is active.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (finish) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. Operands are captured only on accept.
    // The result and the flags are captured on the edge that enters DONE.
    // They stay frozen until the next result is ready, which keeps the
    // output stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            sgn_r     <= 1'b0;
            product_r <= '0;
            neg_r     <= 1'b0;
            zero_r    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{ext_a}}, a};
                        mplier <= {ext_b, ext_b, b, 1'b0};
                        acc    <= '0;
                        cnt    <= '0;
                        sgn_r  <= alu_signed;
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mcand  <= {mcand[PW-3:0], 2'b00};
                    mplier <= mplier_shifted;
                    cnt    <= cnt + CNT_W'(1);
                    if (finish) begin
                        product_r <= acc_sum;
                        neg_r     <= sgn_r & acc_sum[PW-1];
                        zero_r    <= (acc_sum == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product   = product_r;
    assign neg_flag  = neg_r;
    assign zero_flag = zero_r;

endmodule

// File: tb/tb_booth_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_mul
//
// Self-checking bench for booth_seq_mul with WIDTH=16. It applies:
//   - a table of directed vectors,
//   - hand-written sequences for backpressure and reset during an operation,
//   - randomized vectors checked against a plain-arithmetic product model.
// Latency expectations depend on BOOTH_EARLY_TERM_EN.
// ---------------------------------------------------------------------------
module tb_booth_seq_mul;

    localparam int W  = 16;
    localparam int PW = 2*W;
    localparam int D  = W/2+1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          alu_signed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] product;
    logic          neg_flag;
    logic          zero_flag;
    logic          busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          sgn;
        logic [PW-1:0] prod;
        logic          neg;
        logic          zero;
    } vec_t;

    vec_t vecs[10];

    booth_seq_mul #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .alu_signed (alu_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product    (product),
        .neg_flag   (neg_flag),
        .zero_flag  (zero_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Compares one value and logs the outcome
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference product computed with wide integer arithmetic
    function automatic logic [PW-1:0] refMul(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn);
        longint lx;
        longint ly;
        lx = sgn ? longint'($signed(x)) : longint'(x);
        ly = sgn ? longint'($signed(y)) : longint'(y);
        return PW'(lx * ly);
    endfunction

    // Random operand biased toward the corner values
    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            4:       return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    // Presents one operation, then scrambles the inputs after accept.
    // Waits a bounded time for out_valid and returns the latency in cycles.
    task automatic applyStimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic sgn,
                                 output logic [PW-1:0] res, output logic neg, output logic zero,
                                 output int lat);
        @(negedge clk);
        a          = op_a;
        b          = op_b;
        alu_signed = sgn;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        a          = W'($urandom);
        b          = W'($urandom);
        alu_signed = ~sgn;
        lat = 0;
        while (!out_valid && lat < 4*D) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res  = product;
        neg  = neg_flag;
        zero = zero_flag;
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic checkLatency(input string name, input int lat);
`ifdef BOOTH_EARLY_TERM_EN
        checkOutput(name, 64'(lat >= 1 && lat <= D), 64'd1);
`else
        checkOutput(name, 64'(lat), 64'(D));
`endif
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [PW-1:0] res;
        logic          neg;
        logic          zero;
        int            lat;
        int            seen;

        vecs[0] = '{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 1'b1, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, 1'b1, 1'b0};
        vecs[5] = '{16'h0100, 16'h0003, 1'b0, 32'h00000300, 1'b0, 1'b0};
        vecs[6] = '{16'h1234, 16'h0000, 1'b0, 32'h00000000, 1'b0, 1'b1};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 32'h40000000, 1'b0, 1'b0};
        vecs[8] = '{16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF, 1'b0, 1'b0};
        vecs[9] = '{16'h0001, 16'hFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};

        // Asynchronous reset, checked before any clock edge
        #2;
        rst_n = 1'b0;
        #2;
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset product", 64'(product), 64'd0);
        checkOutput("reset neg_flag", 64'(neg_flag), 64'd0);
        checkOutput("reset zero_flag", 64'(zero_flag), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, res, neg, zero, lat);
            checkLatency($sformatf("vec%0d latency", i), lat);
            checkOutput($sformatf("vec%0d product", i), 64'(res), 64'(vecs[i].prod));
            checkOutput($sformatf("vec%0d neg_flag", i), 64'(neg), 64'(vecs[i].neg));
            checkOutput($sformatf("vec%0d zero_flag", i), 64'(zero), 64'(vecs[i].zero));
`ifdef BOOTH_EARLY_TERM_EN
            if (i == 5) begin
                checkOutput("early term latency", 64'(lat), 64'd2);
            end
`endif
            releaseResult();
            checkOutput($sformatf("vec%0d in_ready after", i), 64'(in_ready), 64'd1);
        end

        // Zero product with backpressure. in_valid is ignored while in DONE.
        @(negedge clk);
        a = 16'h1234; b = 16'h0000; alu_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp busy in calc", 64'(busy), 64'd1);
        checkOutput("bp in_ready in calc", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 4*D) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkLatency("bp latency", lat);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            a = 16'h0005; b = 16'h0005;
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp hold%0d out_valid", k), 64'(out_valid), 64'd1);
            checkOutput($sformatf("bp hold%0d product", k), 64'(product), 64'd0);
            checkOutput($sformatf("bp hold%0d zero_flag", k), 64'(zero_flag), 64'd1);
            checkOutput($sformatf("bp hold%0d in_ready", k), 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        releaseResult();
        checkOutput("bp in_ready return", 64'(in_ready), 64'd1);
        checkOutput("bp out_valid drop", 64'(out_valid), 64'd0);

        // Randomized vectors checked against the arithmetic model
        for (int n = 0; n < 300; n++) begin
            logic [W-1:0]  ra;
            logic [W-1:0]  rb;
            logic          rs;
            logic [PW-1:0] exp_p;
            ra = pickOperand();
            rb = pickOperand();
            rs = 1'($urandom_range(0, 1));
            exp_p = refMul(ra, rb, rs);
            applyStimulus(ra, rb, rs, res, neg, zero, lat);
            checkLatency($sformatf("rnd%0d latency", n), lat);
            checkOutput($sformatf("rnd%0d product a=%0h b=%0h s=%0d", n, ra, rb, rs), 64'(res), 64'(exp_p));
            checkOutput($sformatf("rnd%0d neg_flag", n), 64'(neg), 64'(rs & exp_p[PW-1]));
            checkOutput($sformatf("rnd%0d zero_flag", n), 64'(zero), 64'(exp_p == '0));
            releaseResult();
        end

        // Leave a nonzero product in place so the reset clear can be seen
        applyStimulus(16'd3, 16'd5, 1'b0, res, neg, zero, lat);
        checkOutput("pre-reset product", 64'(res), 64'd15);
        releaseResult();

        // Reset during the fourth CALC cycle aborts the operation
        @(negedge clk);
        a = 16'd7; b = 16'd9; alu_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset in_ready", 64'(in_ready), 64'd1);
        checkOutput("midreset product", 64'(product), 64'd0);
        checkOutput("midreset busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 2*D; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("midreset no result", 64'(seen), 64'd0);
        applyStimulus(16'd2, 16'd3, 1'b0, res, neg, zero, lat);
        checkLatency("post-reset latency", lat);
        checkOutput("post-reset product", 64'(res), 64'd6);
        releaseResult();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
